mem_port_arbiter: RTL and testbench

- Shares one single-ported unified instruction/data memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage pipeline.
- Sequences each access through a small FSM and registers the memory-side outputs.
- Returns read data and a one-cycle done pulse to the winning requester.
- Emits per-stage stall signals so the pipeline holds while its access is pending.

---
 rtl/mem_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch and the
// data (load/store) stage. A three-state FSM serialises the accesses. All
// memory-side outputs, done pulses and read data are registered. The stall
// outputs are combinational.
//
// Optional feature macro: TIMEOUT_EN
//   When TIMEOUT_EN is defined, an access whose mem_ready has not arrived
//   after TIMEOUT_CYCLES waiting cycles is aborted. The abort pulses done and
//   bus_err and returns zero data. When TIMEOUT_EN is undefined, bus_err is
//   tied to 0 and an access waits indefinitely.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   if_req/if_addr       fetch request (level) and address
//   if_done/if_rdata     fetch completion pulse and registered fetch data
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, data
//   dm_done/dm_rdata     data completion pulse and registered load data
//   stall_if, stall_mem  pipeline hold requests
//   mem_req/mem_we/mem_addr/mem_wdata  registered memory command
//   mem_ready/mem_rdata  memory completion and read data
//   bus_err              pulse coincident with a done caused by timeout
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [3:0]        burst_q, burst_d;
  logic              if_elig, dm_elig;
  logic              complete, abort;

`ifdef TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       bus_err_q, bus_err_d;
`endif

  // A requester whose done is high this cycle is still holding the request
  // that just completed. Blocking it here keeps that request from being
  // re-granted.
  assign if_elig = if_req & ~if_done_q;
  assign dm_elig = dm_req & ~dm_done_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    burst_d     = burst_q;
    complete    = 1'b0;
    abort       = 1'b0;
`ifdef TIMEOUT_EN
    tmo_d       = tmo_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Data has priority until it has won MAX_DATA_BURST grants in a row
        // while fetch competes. After that, fetch gets the next slot.
        if (dm_elig && (!if_elig || burst_q < BURST_MAX)) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (burst_q < BURST_MAX) burst_d = burst_q + 4'd1;
`ifdef TIMEOUT_EN
          tmo_d = '0;
`endif
        end else if (if_elig) begin
          state_d    = BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          burst_d    = '0;
`ifdef TIMEOUT_EN
          tmo_d = '0;
`endif
        end else if (!if_req) begin
          burst_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // A mem_ready that arrives in the last allowed cycle still wins over the abort.
        if (mem_ready) complete = 1'b1;
`ifdef TIMEOUT_EN
        else if (tmo_q == TMO_LAST) abort = 1'b1;
        else tmo_d = tmo_q + 8'd1;
`endif
        if (complete || abort) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!if_req) burst_d = '0;
`ifdef TIMEOUT_EN
          bus_err_d = abort;
`endif
          if (state_q == BUSY_I) begin
            if_done_d  = 1'b1;
            if_rdata_d = abort ? '0 : mem_rdata;
          end else begin
            dm_done_d = 1'b1;
            if (abort) dm_rdata_d = '0;
            else if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      burst_q     <= burst_d;
    end
  end

`ifdef TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_done_q;
  assign stall_mem = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        if_done, dm_done, stall_if, stall_mem;
  logic        mem_req, mem_we, bus_err;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(MAXB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {int stamp; logic we; logic [31:0] addr; logic [31:0] wdata;} gnt_t;
  typedef struct {int stamp; logic [31:0] data; logic err;} done_t;

  gnt_t  gq[$];
  done_t ifq[$];
  done_t dmq[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state
  logic [31:0] mem [logic [31:0]];
  int          m_st = 0;          // 0 idle, 1 fetch access, 2 data access
  int          m_burst = 0;
  int          m_wait = 0;
  int          rsp_cnt = 0;
  int          fixed_delay = -1;
  logic        m_if_done = 1'b0, m_dm_done = 1'b0;
  logic        m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_dm_rdata = '0;
  logic        agents_on = 1'b0, hold_dm = 1'b0;
  logic [31:0] if_hold = '0, dm_hold = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] memval(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic int pick_delay();
    if (fixed_delay >= 0) return fixed_delay;
    if ($urandom_range(0, 39) == 0) begin
      case ($urandom_range(0, 3))
        0: return TMO - 2;
        1: return TMO - 1;
        2: return TMO;
        default: return TMO + 6;
      endcase
    end
    return int'($urandom_range(0, 3));
  endfunction

  task automatic grant();
    gnt_t g;
    g.stamp = cyc; g.we = m_we; g.addr = m_addr; g.wdata = m_wdata;
    gq.push_back(g);
    m_wait = 0;
    rsp_cnt = pick_delay();
  endtask

  // Applies the arbitration rules to the inputs that were present at the edge just passed.
  task automatic model_edge();
    logic  nd_if, nd_dm, if_el, dm_el, fin, ab;
    done_t d;
    nd_if = 1'b0; nd_dm = 1'b0;
    if (m_st == 0) begin
      if_el = if_req && !m_if_done;
      dm_el = dm_req && !m_dm_done;
      if (dm_el && (!if_el || m_burst < MAXB)) begin
        m_st = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        if (m_burst < MAXB) m_burst++;
        grant();
      end else if (if_el) begin
        m_st = 1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_burst = 0;
        grant();
      end else if (!if_req) begin
        m_burst = 0;
      end
    end else begin
      fin = mem_ready;
      ab  = 1'b0;
      if (!fin) begin
        m_wait++;
`ifdef TIMEOUT_EN
        if (m_wait == TMO) ab = 1'b1;
`endif
      end
      if (fin || ab) begin
        d.stamp = cyc; d.err = ab;
        if (m_st == 1) begin
          d.data = ab ? 32'h0 : memval(m_addr);
          ifq.push_back(d);
          nd_if = 1'b1;
        end else begin
          if (ab) m_dm_rdata = '0;
          else if (m_we) mem[m_addr] = m_wdata;
          else m_dm_rdata = memval(m_addr);
          d.data = m_dm_rdata;
          dmq.push_back(d);
          nd_dm = 1'b1;
        end
        if (!if_req) m_burst = 0;
        m_st = 0;
      end
    end
    m_if_done = nd_if;
    m_dm_done = nd_dm;
  endtask

  task automatic new_dm();
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = 32'h2000 + ($urandom_range(0, 7) << 2);
    dm_wdata = $urandom;
  endtask

  task automatic drive();
    logic keep;
    if (m_if_done) begin
      keep = agents_on ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (keep) if_addr = 32'h100 + ($urandom_range(0, 63) << 2);
      else if_req = 1'b0;
    end else if (agents_on && !if_req && $urandom_range(0, 2) == 0) begin
      if_req  = 1'b1;
      if_addr = 32'h100 + ($urandom_range(0, 63) << 2);
    end
    if (m_dm_done) begin
      keep = agents_on ? ($urandom_range(0, 1) == 1) : hold_dm;
      if (keep) begin
        if (agents_on) new_dm();
      end else dm_req = 1'b0;
    end else if (agents_on && !dm_req && $urandom_range(0, 1) == 0) begin
      dm_req = 1'b1;
      new_dm();
    end
    if (m_st != 0) begin
      mem_ready = (rsp_cnt == 0);
      mem_rdata = (m_st == 1 || !m_we) ? memval(m_addr) : $urandom;
      if (rsp_cnt > 0) rsp_cnt--;
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    drive();
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_done", 32'(if_done), 0);
    check("rst_dm_done", 32'(dm_done), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_stall_if", 32'(stall_if), 0);
    check("rst_stall_mem", 32'(stall_mem), 0);
    check("rst_bus_err", 32'(bus_err), 0);
  endtask

  // Monitor: pops expected grants and completions as the DUT presents them.
  initial begin
    gnt_t  g;
    done_t d;
    logic  prev_req, exp_if, exp_dm;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) prev_req = 1'b0;
      else begin
        if (mem_req && !prev_req) begin
          if (gq.size() == 0) check("unexpected_grant", 32'(mem_req), 0);
          else begin
            g = gq.pop_front();
            check("grant_cycle", cyc, g.stamp);
            check("grant_we", 32'(mem_we), 32'(g.we));
            check("grant_addr", mem_addr, g.addr);
            if (g.we) check("grant_wdata", mem_wdata, g.wdata);
          end
        end else if (gq.size() != 0 && gq[0].stamp <= cyc) begin
          check("grant_missing", 32'(mem_req), 1);
          gq.delete(0);
        end
        exp_if = (ifq.size() != 0) && (ifq[0].stamp == cyc);
        exp_dm = (dmq.size() != 0) && (dmq[0].stamp == cyc);
        if (if_done || exp_if) begin
          check("if_done", 32'(if_done), 32'(exp_if));
          if (exp_if) begin
            d = ifq.pop_front();
            if_hold = d.data;
            check("if_bus_err", 32'(bus_err), 32'(d.err));
          end
        end
        if (dm_done || exp_dm) begin
          check("dm_done", 32'(dm_done), 32'(exp_dm));
          if (exp_dm) begin
            d = dmq.pop_front();
            dm_hold = d.data;
            check("dm_bus_err", 32'(bus_err), 32'(d.err));
          end
        end
        if (!exp_if && !exp_dm) check("bus_err_idle", 32'(bus_err), 0);
        check("if_rdata", if_rdata, if_hold);
        check("dm_rdata", dm_rdata, dm_hold);
        check("stall_if", 32'(stall_if), 32'(if_req & ~exp_if));
        check("stall_mem", 32'(stall_mem), 32'(dm_req & ~exp_dm));
        if (!mem_req) check("mem_we_idle", 32'(mem_we), 0);
        prev_req = mem_req;
      end
    end
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    #2 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch from 0x100
    mem[32'h100] = 32'h00500093;
    fixed_delay = 1;
    if_req = 1'b1; if_addr = 32'h100;
    repeat (8) step();
    check("single_fetch_rdata", if_rdata, 32'h00500093);

    // Collision: store and fetch raised together
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h104;
    repeat (12) step();
    check("store_keeps_dm_rdata", dm_rdata, 32'h0);

    // Held load request through and after its done
    fixed_delay = 0;
    hold_dm = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    repeat (9) step();
    hold_dm = 1'b0;
    repeat (6) step();
    check("held_load_rdata", dm_rdata, 32'hDEADBEEF);

    // Randomized traffic
    fixed_delay = -1;
    agents_on = 1'b1;
    repeat (3000) step();

    // Asynchronous reset in the middle of a data access
    n = 0;
    while (m_st != 2 && n < 300) begin step(); n++; end
    check("reach_busy_d", 32'(m_st), 2);
    check("pre_reset_mem_req", 32'(mem_req), 32'(m_st != 0));
    #2;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    #1 check_reset_outputs();
    m_st = 0; m_burst = 0; m_if_done = 1'b0; m_dm_done = 1'b0; m_dm_rdata = '0;
    if_hold = '0; dm_hold = '0;
    gq.delete(); ifq.delete(); dmq.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) step();

    // Drain outstanding requests
    agents_on = 1'b0;
    n = 0;
    while ((if_req || dm_req || m_st != 0) && n < 1000) begin step(); n++; end
    check("drain_idle", 32'(if_req | dm_req), 0);
    repeat (3) step();
    check("grants_left", gq.size(), 0);
    check("if_done_left", ifq.size(), 0);
    check("dm_done_left", dmq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
